mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide unit controller for the pipelined MIPS core. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per idle cycle from the E stage, sequences the fixed-latency multiply or divide, and owns the architectural HI/LO registers. It exports `busy` and a stall request so the hazard unit can hold any later MDU instruction (including MFHI/MFLO) in D until the result is committed.

---
 rtl/mdu_ctrl.sv | 132 +++++++++++++
 tb/tb_mdu_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences fixed-latency MULT/DIV operations,
// owns the architectural HI/LO registers and raises a stall while busy.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul, is_div, is_sgn, idle;
  logic [63:0] mul_a, mul_b, product;
  logic        a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign is_mul = (mdu_op == OpMult) || (mdu_op == OpMultu);
  assign is_div = (mdu_op == OpDiv) || (mdu_op == OpDivu);
  assign is_sgn = (mdu_op == OpMult) || (mdu_op == OpDiv);
  assign idle   = (state_q == StIdle);

  // Sign-extended 64x64 product truncated to 64 bits covers both signednesses.
  assign mul_a   = {(is_sgn ? {32{rs_val[31]}} : 32'h0), rs_val};
  assign mul_b   = {(is_sgn ? {32{rt_val[31]}} : 32'h0), rt_val};
  assign product = mul_a * mul_b;

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg       = is_sgn & rs_val[31];
  assign b_neg       = is_sgn & rt_val[31];
  assign a_mag       = a_neg ? (32'h0 - rs_val) : rs_val;
  assign b_mag       = b_neg ? (32'h0 - rt_val) : rt_val;
  assign div_by_zero = (rt_val == 32'h0);
  assign b_safe      = div_by_zero ? 32'h1 : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign quot        = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
  assign rem         = a_neg ? (32'h0 - r_mag) : r_mag;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    if (idle) begin
      if (start && is_mul) begin
        pend_hi_d    = product[63:32];
        pend_lo_d    = product[31:0];
        pend_valid_d = 1'b1;
        cnt_d        = MultLoad;
        state_d      = StRun;
      end else if (start && is_div) begin
        pend_hi_d    = rem;
        pend_lo_d    = quot;
        pend_valid_d = ~div_by_zero;
        cnt_d        = DivLoad;
        state_d      = StRun;
      end else if (start && (mdu_op == OpMthi)) begin
        hi_d = rs_val;
      end else if (start && (mdu_op == OpMtlo)) begin
        lo_d = rs_val;
      end
    end else begin
      if (cnt_q > 4'd1) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        if (pend_valid_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      pend_hi_q    <= 32'h0;
      pend_lo_q    <= 32'h0;
      pend_valid_q <= 1'b0;
      hi_q         <= 32'h0;
      lo_q         <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign stall_req = busy | (start & (is_mul | is_div));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mdu_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div, count busy cycles (bounded), then check latency and HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    #1;
    check({tag, "_stall_start"}, 32'(stall_req), 32'd1);
    tick();
    start = 1'b0; mdu_op = 4'd0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'h0; rt_val = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_stall", 32'(stall_req), 32'd0);
    start = 1'b1; mdu_op = 4'd5;
    #1;
    check("stall_mthi", 32'(stall_req), 32'd0);
    mdu_op = 4'd3;
    #1;
    check("stall_div", 32'(stall_req), 32'd1);
    start = 1'b0; mdu_op = 4'd0;

    run_op("mult", 4'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 4'd4, 32'h7, 32'h2, 10, 32'h1, 32'h3);

    // MTHI then divide by zero: HI keeps the moved value, LO keeps 3
    start = 1'b1; mdu_op = 4'd5; rs_val = 32'h12345678;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", 32'(busy), 32'd0);
    run_op("div0", 4'd3, 32'h55, 32'h0, 10, 32'h12345678, 32'h3);
    run_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    // Unknown op leaves everything alone
    start = 1'b1; mdu_op = 4'd9; rs_val = 32'h5;
    #1;
    check("op9_stall", 32'(stall_req), 32'd0);
    tick();
    start = 1'b0; mdu_op = 4'd0;
    check("op9_busy", 32'(busy), 32'd0);
    check("op9_hi", hi, 32'h0);
    check("op9_lo", lo, 32'h80000000);

    // MULT 3 * -5 with an MTLO injected in busy cycle 2
    start = 1'b1; mdu_op = 4'd1; rs_val = 32'h3; rt_val = 32'hFFFFFFFB;
    #1;
    check("inj_stall_start", 32'(stall_req), 32'd1);
    tick();
    start = 1'b0; mdu_op = 4'd0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        start = 1'b1; mdu_op = 4'd6; rs_val = 32'hDEADBEEF;
      end else begin
        start = 1'b0; mdu_op = 4'd0;
      end
      #1;
      check($sformatf("inj_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("inj_stall_c%0d", c), 32'(stall_req), 32'd1);
      if (c == 3) check("inj_lo_during_run", lo, 32'h80000000);
      tick();
    end
    start = 1'b0; mdu_op = 4'd0;
    check("inj_busy_after", 32'(busy), 32'd0);
    check("inj_stall_after", 32'(stall_req), 32'd0);
    check("inj_hi", hi, 32'hFFFFFFFF);
    check("inj_lo", lo, 32'hFFFFFFF1);

    // DIVU 100/7 aborted by reset in busy cycle 3
    start = 1'b1; mdu_op = 4'd4; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    tick();
    tick();
    check("abort_busy_c3", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_commit_hi", hi, 32'h0);
    check("abort_no_commit_lo", lo, 32'h0);
    run_op("multu34", 4'd2, 32'd3, 32'd4, 5, 32'h0, 32'd12);

    // Reset and start in the same cycle: reset wins
    start = 1'b1; mdu_op = 4'd5; rs_val = 32'hAAAA5555; reset = 1'b1;
    tick();
    start = 1'b0; mdu_op = 4'd0; reset = 1'b0;
    check("rst_start_hi", hi, 32'h0);
    check("rst_start_lo", lo, 32'h0);
    check("rst_start_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
